abro_event_sequencer: RTL and testbench
=======================================

// Module: abro_event_sequencer
// PURPOSE
//  Sequencing controller in front of one ABROStateMachine instance (inputs A, B, reset; output O).
//  - Takes A and B event requests from upstream requesters through req/ack handshakes.
//  - Turns them into single-cycle A/B pulses, at most one per cycle.
//  - Watches O for completion and counts completed rounds.
//  - Restarts the ABRO machine after each round or on timeout by holding its reset for a fixed time.
// PARAMETERS
//  HOLD_CYCLES     4   cycles abro_reset stays high per restart (>=1)
//  TIMEOUT_CYCLES  8   max cycles in WAIT_O without O before timeout (>=1)
//  CNT_W           8   width of round_cnt
// PORTS
//  clk           in   1      system clock; all logic on posedge
//  reset         in   1      asynchronous, active-high reset
//  enable        in   1      1 = new A/B events may be issued
//  a_req         in   1      A request, level; held until a_ack
//  a_ack         out  1      1-cycle pulse: A forwarded this cycle
//  b_req         in   1      B request, level; held until b_ack
//  b_ack         out  1      1-cycle pulse: B forwarded this cycle
//  abro_A        out  1      A pulse to ABRO machine
//  abro_B        out  1      B pulse to ABRO machine
//  abro_reset    out  1      reset to ABRO machine
//  abro_O        in   1      O output of ABRO machine
//  done          out  1      1-cycle pulse: round completed (O seen)
//  round_cnt     out  CNT_W  completed rounds, wraps 2^CNT_W-1 -> 0
//  err_timeout   out  1      sticky: O not seen within TIMEOUT_CYCLES
//  err_spurious  out  1      sticky: O seen outside WAIT_O
//  busy          out  1      1 when state != COLLECT
// BEHAVIOUR
//  Registers and reset
//  - All outputs are registered.
//  - reset asserted (any time, async) forces the following:
//    - state = RESTART, hold counter = 0.
//    - abro_reset = 1; busy = 1.
//    - abro_A, abro_B, a_ack, b_ack, done = 0.
//    - round_cnt = 0; err_* = 0; seen_a = seen_b = 0.
//  - Reset mid-round discards pending events; no ack is issued for them.
//  FSM states
//  - RESTART
//    - abro_reset = 1 for exactly HOLD_CYCLES cycles, counted from entry.
//    - Then goes to COLLECT with abro_reset = 0 and seen_a = seen_b = 0.
//    - Requests are not served in this state.
//  - COLLECT, while enable = 1:
//    - if a_req && !seen_a: next cycle abro_A = a_ack = 1, set seen_a.
//    - else if b_req && !seen_b: next cycle abro_B = b_ack = 1, set seen_b.
//    - A has priority on simultaneous requests; B is served the following cycle.
//    - A request whose event is already seen waits, un-acked, until the next round.
//    - enable = 0 freezes issuing; the state is kept.
//    - When seen_a && seen_b: go to WAIT_O, timer = 0.
//  - WAIT_O (enable is ignored)
//    - abro_O = 1: done pulse, round_cnt += 1, go to RESTART.
//    - Timer reaches TIMEOUT_CYCLES with no O: err_timeout = 1, go to RESTART; round_cnt unchanged.
//    - O in the timeout cycle: O wins; no error.
//  Errors
//  - abro_O = 1 in COLLECT or RESTART: err_spurious = 1; the state is unaffected.
//  - err_* clear only on reset.
//  Latency
//  - req sampled at edge N -> abro_X/ack high during cycle N+1.
//  - Last event issued -> WAIT_O one cycle later.
//  - O sampled -> done in the next cycle, with abro_reset high in that same cycle.
// TESTING
//  T1 reset 2 cycles, release, no requests:
//     abro_reset high for 4 cycles then 0; busy falls; all pulses stay 0.
//  T2 a_req, then b_req 3 cycles later, O returned 1 cycle after abro_B:
//     one abro_A, one abro_B; done pulse; round_cnt=1; 4-cycle restart.
//  T3 a_req & b_req raised in the same cycle:
//     abro_A/a_ack in cycle N+1, abro_B/b_ack in cycle N+2, never both at once.
//  T4 both events issued, O never asserted:
//     err_timeout=1 after 8 WAIT_O cycles; restart; round_cnt unchanged.
//  T5 O asserted in COLLECT:
//     err_spurious=1, collection continues; then reset asserted during WAIT_O:
//     all outputs at reset values immediately (async).
//  T6 run 256 rounds with CNT_W=8:
//     round_cnt wraps 255->0; A held high in second round waits un-acked until restart.

Source files
------------

// File: rtl/abro_event_sequencer_if.sv
// Handshake and ABRO-machine signal bundle for abro_event_sequencer.
// The master side is the environment (requesters plus the ABRO machine); the slave side is the sequencer.
interface abro_event_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             enable;
   logic             a_req;
   logic             a_ack;
   logic             b_req;
   logic             b_ack;
   logic             abro_A;
   logic             abro_B;
   logic             abro_reset;
   logic             abro_O;
   logic             done;
   logic [CNT_W-1:0] round_cnt;
   logic             err_timeout;
   logic             err_spurious;
   logic             busy;

   modport master (
      output enable, a_req, b_req, abro_O,
      input  a_ack, b_ack, abro_A, abro_B, abro_reset, done,
             round_cnt, err_timeout, err_spurious, busy
   );

   modport slave (
      input  enable, a_req, b_req, abro_O,
      output a_ack, b_ack, abro_A, abro_B, abro_reset, done,
             round_cnt, err_timeout, err_spurious, busy
   );
endinterface

// File: rtl/abro_event_sequencer.sv
// Feeds A/B events to one ABRO machine, waits for O, counts rounds and
// restarts the machine after every round or timeout by holding its reset.
module abro_event_sequencer #(
   parameter int HOLD_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 8,
   parameter int CNT_W          = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   abro_event_sequencer_if.slave   bus
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RESTART = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WAIT_O  = 2'd2
   } state_t;

   state_t           state_r;
   logic [HW-1:0]    hold_cnt_r;
   logic [TW-1:0]    timer_r;
   logic             seen_a_r;
   logic             seen_b_r;
   logic             a_pulse_r;
   logic             b_pulse_r;
   logic             abro_reset_r;
   logic             done_r;
   logic [CNT_W-1:0] round_cnt_r;
   logic             err_timeout_r;
   logic             err_spurious_r;
   logic             busy_r;

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r        <= ST_RESTART;
         hold_cnt_r     <= '0;
         timer_r        <= '0;
         seen_a_r       <= 1'b0;
         seen_b_r       <= 1'b0;
         a_pulse_r      <= 1'b0;
         b_pulse_r      <= 1'b0;
         abro_reset_r   <= 1'b1;
         done_r         <= 1'b0;
         round_cnt_r    <= '0;
         err_timeout_r  <= 1'b0;
         err_spurious_r <= 1'b0;
         busy_r         <= 1'b1;
      end else begin
         a_pulse_r <= 1'b0;
         b_pulse_r <= 1'b0;
         done_r    <= 1'b0;
         case (state_r)
            ST_RESTART: begin
               if (bus.abro_O) begin
                  err_spurious_r <= 1'b1;
               end
               if (hold_cnt_r == HOLD_LAST) begin
                  state_r      <= ST_COLLECT;
                  hold_cnt_r   <= '0;
                  abro_reset_r <= 1'b0;
                  busy_r       <= 1'b0;
                  seen_a_r     <= 1'b0;
                  seen_b_r     <= 1'b0;
               end else begin
                  hold_cnt_r <= hold_cnt_r + HW'(1);
               end
            end
            ST_COLLECT: begin
               if (bus.abro_O) begin
                  err_spurious_r <= 1'b1;
               end
               if (seen_a_r && seen_b_r) begin
                  state_r <= ST_WAIT_O;
                  timer_r <= '0;
                  busy_r  <= 1'b1;
               end else if (bus.enable) begin
                  // A wins a tie; B is picked up on the following edge.
                  if (bus.a_req && !seen_a_r) begin
                     a_pulse_r <= 1'b1;
                     seen_a_r  <= 1'b1;
                  end else if (bus.b_req && !seen_b_r) begin
                     b_pulse_r <= 1'b1;
                     seen_b_r  <= 1'b1;
                  end
               end
            end
            ST_WAIT_O: begin
               if (bus.abro_O) begin
                  done_r       <= 1'b1;
                  round_cnt_r  <= round_cnt_r + CNT_W'(1);
                  state_r      <= ST_RESTART;
                  hold_cnt_r   <= '0;
                  abro_reset_r <= 1'b1;
               end else if (timer_r == TO_LAST) begin
                  err_timeout_r <= 1'b1;
                  state_r       <= ST_RESTART;
                  hold_cnt_r    <= '0;
                  abro_reset_r  <= 1'b1;
               end else begin
                  timer_r <= timer_r + TW'(1);
               end
            end
            default: begin
               state_r      <= ST_RESTART;
               hold_cnt_r   <= '0;
               abro_reset_r <= 1'b1;
               busy_r       <= 1'b1;
            end
         endcase
      end
   end

   assign bus.abro_A       = a_pulse_r;
   assign bus.a_ack        = a_pulse_r;
   assign bus.abro_B       = b_pulse_r;
   assign bus.b_ack        = b_pulse_r;
   assign bus.abro_reset   = abro_reset_r;
   assign bus.done         = done_r;
   assign bus.round_cnt    = round_cnt_r;
   assign bus.err_timeout  = err_timeout_r;
   assign bus.err_spurious = err_spurious_r;
   assign bus.busy         = busy_r;

endmodule

// File: tb/tb_abro_event_sequencer.sv
// Directed bench for abro_event_sequencer: stimulus pushes expected events
// (kind, cycle, round count) into a queue; a negedge monitor pops and compares.
module tb_abro_event_sequencer;

   localparam int EV_A    = 0;
   localparam int EV_B    = 1;
   localparam int EV_DONE = 2;
   localparam int EV_TO   = 3;
   localparam int HOLD    = 4;

   typedef struct {
      int         kind;
      int         cyc;
      logic [7:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];
   logic [7:0] exp_cnt = 8'd0;
   int   run = 0;
   logic prev_to = 1'b0;

   abro_event_sequencer_if #(.CNT_W(8)) bus ();

   abro_event_sequencer #(
      .HOLD_CYCLES   (4),
      .TIMEOUT_CYCLES(8),
      .CNT_W         (8)
   ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input int kind, input int c, input logic [7:0] cnt);
      exp_t e;
      e.kind = kind;
      e.cyc  = c;
      e.cnt  = cnt;
      sb.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic check_reset_vals(input string name);
      logic [16:0] got;
      logic [16:0] want;
      got  = {bus.abro_reset, bus.busy, bus.abro_A, bus.abro_B, bus.a_ack, bus.b_ack,
              bus.done, bus.round_cnt, bus.err_timeout, bus.err_spurious};
      want = {1'b1, 1'b1, 5'b00000, 8'h00, 2'b00};
      check(name, 32'(got), 32'(want));
   endtask

   task automatic pop_check(input int kind);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got kind=%0d at cycle %0d, expected no event", kind, cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.cyc != cyc || e.cnt !== bus.round_cnt) begin
            fails++;
            $display("FAIL event: got kind=%0d cyc=%0d cnt=%0d, expected kind=%0d cyc=%0d cnt=%0d",
                     kind, cyc, bus.round_cnt, e.kind, e.cyc, e.cnt);
         end
      end
   endtask

   // Monitor: event scoreboard plus restart-length and pulse-pairing checks.
   always @(negedge clk) begin
      if (rst) begin
         run     = 0;
         prev_to = 1'b0;
      end else begin
         if (bus.a_ack || bus.b_ack || bus.abro_A || bus.abro_B)
            check("pulse_pairing", {bus.abro_A, bus.abro_B, bus.a_ack && bus.b_ack},
                  {bus.a_ack, bus.b_ack, 1'b0});
         if (bus.a_ack) pop_check(EV_A);
         if (bus.b_ack) pop_check(EV_B);
         if (bus.done) pop_check(EV_DONE);
         if (bus.err_timeout && !prev_to) pop_check(EV_TO);
         prev_to = bus.err_timeout;
         if (bus.abro_reset) begin
            run++;
         end else if (run != 0) begin
            check("restart_len_busy", {run, 31'(bus.busy)}, {HOLD, 31'(0)});
            run = 0;
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.busy !== 1'b0 && n < 100);
      if (bus.busy !== 1'b0) begin
         tests++;
         fails++;
         $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", bus.busy, n);
      end
   endtask

   // gap = cycles between raising a_req and b_req (0 = same cycle); ends in the B cycle.
   task automatic issue_pair(input int gap, output int last);
      int k;
      int bt;
      k    = cyc;
      bt   = (gap == 0) ? 1 : gap;
      last = k + bt + 1;
      push_ev(EV_A, k + 1, exp_cnt);
      push_ev(EV_B, last, exp_cnt);
      bus.a_req = 1'b1;
      if (gap == 0) bus.b_req = 1'b1;
      for (int t = 1; t <= bt + 1; t++) begin
         tick();
         if (t == 1) bus.a_req = 1'b0;
         if (gap > 0 && t == gap) bus.b_req = 1'b1;
         if (t == bt + 1) bus.b_req = 1'b0;
      end
   endtask

   // Called in the B cycle; returns O one cycle later and expects done after it.
   task automatic give_o();
      tick();
      bus.abro_O = 1'b1;
      push_ev(EV_DONE, cyc + 1, exp_cnt + 8'd1);
      exp_cnt = exp_cnt + 8'd1;
      tick();
      bus.abro_O = 1'b0;
   endtask

   initial begin
      int last;
      int k;
      int r;
      bus.enable = 1'b1;
      bus.a_req  = 1'b0;
      bus.b_req  = 1'b0;
      bus.abro_O = 1'b0;

      // T1: reset, release, idle restart
      tick();
      tick();
      check_reset_vals("t1_reset_vals");
      rst = 1'b0;
      wait_idle();
      check("t1_idle_outputs", {bus.abro_reset, bus.round_cnt, bus.err_timeout, bus.err_spurious}, 32'd0);

      // T2: A, then B three cycles later, O one cycle after B
      issue_pair(3, last);
      give_o();
      wait_idle();
      check("t2_round_cnt", 32'(bus.round_cnt), 32'd1);

      // T3: simultaneous requests
      issue_pair(0, last);
      give_o();
      wait_idle();

      // T4: no O -> timeout after 8 WAIT_O cycles
      issue_pair(2, last);
      push_ev(EV_TO, last + 9, exp_cnt);
      wait_idle();
      check("t4_timeout_sticky", {bus.err_timeout, bus.round_cnt}, {1'b1, 8'd2});

      // T5: spurious O in COLLECT, then async reset during WAIT_O
      bus.abro_O = 1'b1;
      tick();
      bus.abro_O = 1'b0;
      check("t5_spurious", {bus.err_spurious, bus.busy}, 2'b10);
      issue_pair(1, last);
      tick();
      #1;
      rst = 1'b1;
      #1;
      check_reset_vals("t5_async_reset");
      exp_cnt = 8'd0;
      tick();
      rst = 1'b0;
      wait_idle();

      // T6: 256 rounds, wrap, held A waits for next round, enable freeze
      r = 0;
      while (r < 256) begin
         if (r == 1) begin
            k = cyc;
            bus.a_req = 1'b1;
            push_ev(EV_A, k + 1, exp_cnt);
            tick();
            tick();
            bus.b_req = 1'b1;
            push_ev(EV_B, k + 3, exp_cnt);
            tick();
            bus.b_req = 1'b0;
            give_o();
            push_ev(EV_A, k + 10, exp_cnt);
            while (cyc < k + 10) tick();
            bus.a_req = 1'b0;
            bus.b_req = 1'b1;
            push_ev(EV_B, k + 11, exp_cnt);
            tick();
            bus.b_req = 1'b0;
            give_o();
            r += 2;
         end else if (r == 5) begin
            k = cyc;
            bus.enable = 1'b0;
            bus.a_req  = 1'b1;
            tick();
            tick();
            tick();
            bus.enable = 1'b1;
            push_ev(EV_A, k + 4, exp_cnt);
            tick();
            bus.a_req = 1'b0;
            bus.b_req = 1'b1;
            push_ev(EV_B, k + 5, exp_cnt);
            tick();
            bus.b_req = 1'b0;
            give_o();
            r++;
         end else begin
            issue_pair(r % 3, last);
            give_o();
            r++;
         end
         wait_idle();
      end
      check("t6_wrap", {bus.round_cnt, bus.err_timeout, bus.err_spurious}, {exp_cnt, 2'b00});
      check("t6_wrap_zero", 32'(bus.round_cnt), 32'd0);

      tick();
      tick();
      check("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
